// File: rtl/lsu_dcache_port.sv
// Load/store execution stage: captures one LS issue slot, runs a single
// request/response transaction against the data cache and emits a one-cycle
// result pulse for PRF write-back and ROB completion.
module lsu_dcache_port #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    // issue slot from the READ/EX register
    input  logic              valid_ls,
    input  logic              mode,
    input  logic [TAG_W-1:0]  Px,
    input  logic [DATA_W-1:0] busX,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [TAG_W-1:0]  tag_ROB_ls,
    output logic              busy_ls,
    // data cache request/response
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic              dc_we,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_resp_valid,
    input  logic [DATA_W-1:0] dc_rdata,
    // result to PRF / ROB
    output logic              valid_Result_ls,
    output logic [TAG_W-1:0]  Pw_Result_ls,
    output logic              mode_ls,
    output logic [DATA_W-1:0] Data_Result_ls,
    output logic [TAG_W-1:0]  tag_ROB_Result_ls
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t              state;
    logic                cap_mode;
    logic [TAG_W-1:0]    cap_px;
    logic [TAG_W-1:0]    cap_tag;
    logic [DATA_W-1:0]   cap_data;
    logic [ADDR_W-1:0]   cap_addr;

    // Request fields come straight from the captured slot so they stay
    // stable while the cache backpressures; flush kills the request at once.
    assign busy_ls      = (state != IDLE);
    assign dc_req_valid = (state == REQ) && !flush;
    assign dc_we        = cap_mode;
    assign dc_addr      = cap_addr;
    assign dc_wdata     = cap_data;

    // Transaction FSM with captured operands and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cap_mode          <= 1'b0;
            cap_px            <= '0;
            cap_tag           <= '0;
            cap_data          <= '0;
            cap_addr          <= '0;
            valid_Result_ls   <= 1'b0;
            Pw_Result_ls      <= '0;
            mode_ls           <= 1'b0;
            Data_Result_ls    <= '0;
            tag_ROB_Result_ls <= '0;
        end else begin
            valid_Result_ls <= 1'b0;
            case (state)
                IDLE: begin
                    // Responses seen here are stale (e.g. after reset) and ignored.
                    if (valid_ls && !flush) begin
                        cap_mode <= mode;
                        cap_px   <= Px;
                        cap_tag  <= tag_ROB_ls;
                        cap_data <= busX;
                        cap_addr <= Addr;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (flush)
                        state <= IDLE;
                    else if (dc_req_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (dc_resp_valid) begin
                        state <= IDLE;
                        if (!flush) begin
                            valid_Result_ls   <= 1'b1;
                            Pw_Result_ls      <= cap_px;
                            mode_ls           <= cap_mode;
                            tag_ROB_Result_ls <= cap_tag;
                            Data_Result_ls    <= cap_mode ? '0 : dc_rdata;
                        end
                    end else if (flush) begin
                        // Request already accepted: its response must still be swallowed.
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The response of the flushed op retires the drain whether or
                    // not another flush is active; flush never produces a result here.
                    if (dc_resp_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dcache_port.sv
// Self-checking bench for lsu_dcache_port: table-driven transactions,
// hand-written flush/reset sequences and randomized ops vs. a simple model.
module tb_lsu_dcache_port;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, valid_ls, mode, dc_req_ready, dc_resp_valid;
    logic [TW-1:0] Px, tag_ROB_ls;
    logic [DW-1:0] busX, dc_rdata;
    logic [AW-1:0] Addr;
    logic          busy_ls, dc_req_valid, dc_we, valid_Result_ls, mode_ls;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata, Data_Result_ls;
    logic [TW-1:0] Pw_Result_ls, tag_ROB_Result_ls;

    lsu_dcache_port #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .valid_ls(valid_ls), .mode(mode), .Px(Px), .busX(busX), .Addr(Addr),
        .tag_ROB_ls(tag_ROB_ls), .busy_ls(busy_ls),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_we(dc_we),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata),
        .valid_Result_ls(valid_Result_ls), .Pw_Result_ls(Pw_Result_ls),
        .mode_ls(mode_ls), .Data_Result_ls(Data_Result_ls),
        .tag_ROB_Result_ls(tag_ROB_Result_ls)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          m;
        logic [TW-1:0] px;
        logic [DW-1:0] bx;
        logic [AW-1:0] ad;
        logic [TW-1:0] tg;
        int            rw;       // cycles of dc_req_ready low before accept
        int            sw;       // cycles without response before it arrives
        logic [DW-1:0] rd;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl[6];
    vec_t v;
    logic [DW-1:0] last_data;
    logic [TW-1:0] last_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        valid_ls = 1'b0; flush = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    endtask

    task automatic drive_issue(input vec_t x);
        valid_ls = 1'b1; mode = x.m; Px = x.px; busX = x.bx; Addr = x.ad; tag_ROB_ls = x.tg;
    endtask

    task automatic junk_issue;
        valid_ls = 1'($urandom); mode = 1'($urandom); Px = 5'($urandom);
        busX = 16'($urandom); Addr = 16'($urandom); tag_ROB_ls = 5'($urandom);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy_ls), 0);
        chk({pfx, "_req_valid"}, 32'(dc_req_valid), 0);
        chk({pfx, "_we"}, 32'(dc_we), 0);
        chk({pfx, "_addr"}, 32'(dc_addr), 0);
        chk({pfx, "_wdata"}, 32'(dc_wdata), 0);
        chk({pfx, "_res_valid"}, 32'(valid_Result_ls), 0);
        chk({pfx, "_pw"}, 32'(Pw_Result_ls), 0);
        chk({pfx, "_mode_ls"}, 32'(mode_ls), 0);
        chk({pfx, "_data"}, 32'(Data_Result_ls), 0);
        chk({pfx, "_tag"}, 32'(tag_ROB_Result_ls), 0);
    endtask

    // Issue in the current cycle and return in the cycle the result pulse is due,
    // with all inputs quiet, so the caller may chain the next issue immediately.
    task automatic do_op(input vec_t x);
        flush = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
        drive_issue(x);
        tick;
        for (int i = 0; i <= x.rw; i++) begin
            junk_issue;
            dc_req_ready = (i == x.rw);
            #1;
            chk("req_valid", 32'(dc_req_valid), 1);
            chk("req_we", 32'(dc_we), 32'(x.m));
            chk("req_addr", 32'(dc_addr), 32'(x.ad));
            chk("req_wdata", 32'(dc_wdata), 32'(x.bx));
            chk("req_busy", 32'(busy_ls), 1);
            chk("req_no_result", 32'(valid_Result_ls), 0);
            tick;
        end
        dc_req_ready = 1'b0;
        for (int j = 0; j <= x.sw; j++) begin
            junk_issue;
            dc_resp_valid = (j == x.sw);
            dc_rdata = (j == x.sw) ? x.rd : 16'($urandom);
            #1;
            chk("wait_req_valid", 32'(dc_req_valid), 0);
            chk("wait_busy", 32'(busy_ls), 1);
            chk("wait_no_result", 32'(valid_Result_ls), 0);
            tick;
        end
        quiet;
        dc_rdata = 16'($urandom);
        #1;
        chk("res_valid", 32'(valid_Result_ls), 1);
        chk("res_pw", 32'(Pw_Result_ls), 32'(x.px));
        chk("res_mode", 32'(mode_ls), 32'(x.m));
        chk("res_data", 32'(Data_Result_ls), 32'(x.exp_data));
        chk("res_tag", 32'(tag_ROB_Result_ls), 32'(x.tg));
        chk("res_busy", 32'(busy_ls), 0);
    endtask

    // One idle cycle after a result: pulse gone, result fields held.
    task automatic gap_check(input logic [DW-1:0] d, input logic [TW-1:0] t);
        quiet;
        tick;
        #1;
        chk("pulse_one_cycle", 32'(valid_Result_ls), 0);
        chk("hold_data", 32'(Data_Result_ls), 32'(d));
        chk("hold_tag", 32'(tag_ROB_Result_ls), 32'(t));
    endtask

    initial begin
        rst = 1'b1; quiet; mode = 0; Px = '0; busX = '0; Addr = '0; tag_ROB_ls = '0; dc_rdata = '0;
        //                 m   px     bx        ad        tg     rw sw  rd        exp
        tbl[0] = '{1'b0, 5'd7,  16'h0000, 16'h0010, 5'd3,  0, 0, 16'hBEEF, 16'hBEEF};
        tbl[1] = '{1'b1, 5'd2,  16'h1234, 16'h0020, 5'd9,  3, 0, 16'h5A5A, 16'h0000};
        tbl[2] = '{1'b0, 5'd31, 16'h7777, 16'hFFFF, 5'd31, 0, 2, 16'hFFFF, 16'hFFFF};
        tbl[3] = '{1'b0, 5'd0,  16'h0000, 16'h0000, 5'd0,  1, 1, 16'h0001, 16'h0001};
        tbl[4] = '{1'b1, 5'd15, 16'hFFFF, 16'h8000, 5'd16, 0, 3, 16'hDEAD, 16'h0000};
        tbl[5] = '{1'b0, 5'd4,  16'hAAAA, 16'h0042, 5'd1,  2, 0, 16'h0000, 16'h0000};

        tick; tick;
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // Table: rows chained back-to-back, each issued in the previous result cycle.
        tick;
        for (int k = 0; k < 6; k++) do_op(tbl[k]);
        gap_check(tbl[5].exp_data, tbl[5].tg);
        last_data = tbl[5].exp_data; last_tag = tbl[5].tg;

        // Flush in REQ, coinciding with ready: no request, back to idle.
        v = '{1'b0, 5'd5, 16'h0, 16'h0100, 5'd6, 0, 0, 16'h0, 16'h0};
        drive_issue(v); tick;
        valid_ls = 1'b0; flush = 1'b1; dc_req_ready = 1'b1;
        #1;
        chk("flreq_req_valid", 32'(dc_req_valid), 0);
        tick;
        quiet;
        #1;
        chk("flreq_busy", 32'(busy_ls), 0);
        chk("flreq_no_result", 32'(valid_Result_ls), 0);
        tick;
        #1;
        chk("flreq_no_result2", 32'(valid_Result_ls), 0);
        chk("flreq_hold_data", 32'(Data_Result_ls), 32'(last_data));

        // Flush in WAIT, response two cycles later, then a normal op.
        drive_issue(v); tick;
        valid_ls = 1'b0; dc_req_ready = 1'b1; tick;
        dc_req_ready = 1'b0; flush = 1'b1;
        #1; chk("flwait_busy0", 32'(busy_ls), 1);
        tick; flush = 1'b0;
        #1; chk("flwait_busy1", 32'(busy_ls), 1);
        tick; dc_resp_valid = 1'b1; dc_rdata = 16'h3333;
        #1; chk("flwait_busy2", 32'(busy_ls), 1);
        tick; dc_resp_valid = 1'b0;
        #1;
        chk("flwait_busy_after", 32'(busy_ls), 0);
        chk("flwait_no_result", 32'(valid_Result_ls), 0);
        tick;
        #1; chk("flwait_no_result2", 32'(valid_Result_ls), 0);
        v = '{1'b0, 5'd12, 16'h0, 16'h0200, 5'd13, 1, 1, 16'hC0DE, 16'hC0DE};
        do_op(v);
        gap_check(16'hC0DE, 5'd13);
        last_data = 16'hC0DE; last_tag = 5'd13;

        // Flush in WAIT in the same cycle as the response: result discarded.
        v = '{1'b0, 5'd8, 16'h0, 16'h0300, 5'd20, 0, 0, 16'h1111, 16'h1111};
        drive_issue(v); tick;
        valid_ls = 1'b0; dc_req_ready = 1'b1; tick;
        dc_req_ready = 1'b0; dc_resp_valid = 1'b1; flush = 1'b1; dc_rdata = 16'h1111;
        tick; quiet;
        #1;
        chk("flresp_busy", 32'(busy_ls), 0);
        chk("flresp_no_result", 32'(valid_Result_ls), 0);
        chk("flresp_hold_data", 32'(Data_Result_ls), 32'(last_data));
        chk("flresp_hold_tag", 32'(tag_ROB_Result_ls), 32'(last_tag));

        // Issue under flush in IDLE is not captured.
        drive_issue(v); flush = 1'b1; tick;
        quiet;
        #1; chk("flidle_busy", 32'(busy_ls), 0);
        tick;

        // Randomized ops against the model: stores return 0, loads return rdata,
        // each op completes with 3 + ready waits + response waits cycles.
        for (int n = 0; n < 40; n++) begin
            v.m = 1'($urandom); v.px = 5'($urandom); v.bx = 16'($urandom);
            v.ad = 16'($urandom); v.tg = 5'($urandom);
            v.rw = int'($urandom_range(0, 3)); v.sw = int'($urandom_range(0, 3));
            v.rd = 16'($urandom);
            v.exp_data = v.m ? 16'h0 : v.rd;
            do_op(v);
            if ($urandom_range(0, 1) == 0) gap_check(v.exp_data, v.tg);
        end
        gap_check(v.exp_data, v.tg);

        // Reset in WAIT, then a stray response.
        v = '{1'b1, 5'd3, 16'hABCD, 16'h0400, 5'd7, 0, 0, 16'h0, 16'h0};
        drive_issue(v); tick;
        valid_ls = 1'b0; dc_req_ready = 1'b1; tick;
        dc_req_ready = 1'b0; rst = 1'b1; tick;
        rst = 1'b0; dc_resp_valid = 1'b1; dc_rdata = 16'h9999;
        #1;
        chk_all_zero("rstwait");
        tick; dc_resp_valid = 1'b0;
        #1;
        chk_all_zero("rstwait_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
